// File: rtl/mips16_imem_loader_pkg.sv
// Shared definitions for the mips16_sc instruction-memory loader:
// instruction width, default frame marker and loader state encoding.
package mips16_imem_loader_pkg;

    localparam int unsigned InstrW = 32;
    localparam logic [7:0] SyncByteDefault = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StData,
        StCheck,
        StDone,
        StError
    } loader_state_e;

endpackage

// File: rtl/mips16_byte_packer.sv
// Packs a byte stream (MSB first) into InstrW-bit words; word_valid_o pulses
// for one cycle after the edge that accepted the fourth byte of a word.
module mips16_byte_packer
    import mips16_imem_loader_pkg::*;
(
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              clear_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic              last_byte_o,
    output logic              word_valid_o,
    output logic [InstrW-1:0] word_o
);

    logic [1:0]        idx_q;
    logic [23:0]       acc_q;
    logic [InstrW-1:0] word_q;
    logic              word_valid_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            idx_q        <= 2'd0;
            acc_q        <= 24'd0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            word_valid_q <= 1'b0;
            if (clear_i) begin
                idx_q <= 2'd0;
            end else if (byte_valid_i) begin
                acc_q <= {acc_q[15:0], byte_i};
                idx_q <= idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    word_q       <= {acc_q, byte_i};
                    word_valid_q <= 1'b1;
                end
            end
        end
    end

    assign last_byte_o  = (idx_q == 2'd3);
    assign word_valid_o = word_valid_q;
    assign word_o       = word_q;

endmodule

// File: rtl/mips16_imem_loader.sv
// Framed byte-stream loader: SYNC, LEN_HI, LEN_LO, N*4 data bytes, XOR checksum.
// Writes words from address 0 and releases cpu_hold_o only after a verified frame.
module mips16_imem_loader
    import mips16_imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [7:0]  SYNC_BYTE = SyncByteDefault
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [InstrW-1:0] imem_data_o,
    output logic              cpu_hold_o,
    output logic              busy_o,
    output logic              load_done_o,
    output logic              load_error_o
);

    localparam int unsigned CntW     = ADDR_W + 1;
    localparam logic [31:0] MaxWords = 32'(1) << ADDR_W;

    loader_state_e     state_q, state_d;
    logic [15:0]       len_q;
    logic [7:0]        xor_q;
    logic [CntW-1:0]   cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              busy_q, hold_q, done_q, err_q;

    logic              rx_accept, is_sync, arm, pk_valid, pk_last;
    logic [31:0]       len_new, cnt_inc;

    assign rx_ready_o = ~reset_i;
    assign rx_accept  = rx_valid_i & ~reset_i;
    assign is_sync    = (rx_data_i == SYNC_BYTE);
    assign arm        = rx_accept && is_sync && (state_q inside {StIdle, StDone, StError});
    assign pk_valid   = rx_accept && (state_q == StData);
    assign len_new    = {16'd0, len_q[15:8], rx_data_i};
    assign cnt_inc    = 32'(cnt_q) + 32'd1;

    mips16_byte_packer u_packer (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .clear_i      (arm),
        .byte_valid_i (pk_valid),
        .byte_i       (rx_data_i),
        .last_byte_o  (pk_last),
        .word_valid_o (imem_we_o),
        .word_o       (imem_data_o)
    );

    always_comb begin
        state_d = state_q;
        if (rx_accept) begin
            unique case (state_q)
                StIdle:  if (is_sync) state_d = StLenHi;
                StLenHi: state_d = StLenLo;
                StLenLo: begin
                    if (len_new > MaxWords)   state_d = StError;
                    else if (len_new == 32'd0) state_d = StCheck;
                    else                       state_d = StData;
                end
                StData:  if (pk_last && cnt_inc == {16'd0, len_q}) state_d = StCheck;
                StCheck: state_d = (rx_data_i == xor_q) ? StDone : StError;
                StDone, StError: if (is_sync) state_d = StLenHi;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            len_q   <= 16'd0;
            xor_q   <= 8'd0;
            cnt_q   <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= state_d inside {StLenHi, StLenLo, StData, StCheck};
            hold_q  <= (state_d != StDone);
            done_q  <= (state_d == StDone);
            err_q   <= (state_d == StError);
            if (arm) begin
                xor_q <= 8'd0;
                cnt_q <= '0;
            end else if (rx_accept && (state_q inside {StLenHi, StLenLo, StData})) begin
                xor_q <= xor_q ^ rx_data_i;
            end
            if (rx_accept && state_q == StLenHi) len_q[15:8] <= rx_data_i;
            if (rx_accept && state_q == StLenLo) len_q[7:0]  <= rx_data_i;
            // Address is latched on the same edge the packer registers the word.
            if (pk_valid && pk_last) begin
                addr_q <= cnt_q[ADDR_W-1:0];
                cnt_q  <= cnt_q + CntW'(1);
            end
        end
    end

    assign imem_addr_o  = addr_q;
    assign cpu_hold_o   = hold_q;
    assign busy_o       = busy_q;
    assign load_done_o  = done_q;
    assign load_error_o = err_q;

endmodule

// File: tb/tb_mips16_imem_loader.sv
// Randomized self-checking bench for mips16_imem_loader against a frame-level model.
module tb_mips16_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready, imem_we, cpu_hold, busy, load_done, load_error;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_count = 0;
    logic [31:0] frame_words[$];

    always #5 clk = ~clk;

    mips16_imem_loader dut (
        .clock_i      (clk),
        .reset_i      (rst),
        .rx_data_i    (rx_data),
        .rx_valid_i   (rx_valid),
        .rx_ready_o   (rx_ready),
        .imem_we_o    (imem_we),
        .imem_addr_o  (imem_addr),
        .imem_data_o  (imem_data),
        .cpu_hold_o   (cpu_hold),
        .busy_o       (busy),
        .load_done_o  (load_done),
        .load_error_o (load_error)
    );

    always @(negedge clk) if (imem_we) wr_count++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Byte held valid across exactly one rising edge, after `gap` idle cycles.
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("ready_in_reset", {31'd0, rx_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_hold", {31'd0, cpu_hold}, 32'd1);
        check("rst_we", {31'd0, imem_we}, 32'd0);
        check("rst_flags", {29'd0, busy, load_done, load_error}, 32'd0);
        check("rst_ready", {31'd0, rx_ready}, 32'd1);
        check("rst_addr_data", {24'd0, imem_addr} | imem_data, 32'd0);
    endtask

    // Sends frame_words as a complete frame; checksum optionally corrupted.
    task automatic run_frame(input bit bad_chk, input int max_gap);
        int          n     = frame_words.size();
        int          wr0   = wr_count;
        logic [7:0]  chk   = 8'd0;
        logic [15:0] len16 = 16'(n);
        logic [31:0] w;
        logic [7:0]  b;
        send_byte(8'hA5, $urandom_range(max_gap, 0));
        check("sync_busy", {30'd0, busy, cpu_hold}, 32'd3);
        send_byte(len16[15:8], $urandom_range(max_gap, 0));
        send_byte(len16[7:0], $urandom_range(max_gap, 0));
        chk = len16[15:8] ^ len16[7:0];
        for (int k = 0; k < n; k++) begin
            w = frame_words[k];
            for (int j = 3; j >= 0; j--) begin
                b   = w[j*8 +: 8];
                chk = chk ^ b;
                send_byte(b, $urandom_range(max_gap, 0));
                if (j != 0) check("no_early_we", {31'd0, imem_we}, 32'd0);
            end
            check("we", {31'd0, imem_we}, 32'd1);
            check("addr", {24'd0, imem_addr}, k);
            check("data", imem_data, w);
            check("hold_busy", {30'd0, busy, cpu_hold}, 32'd3);
        end
        send_byte(bad_chk ? (chk ^ 8'h01) : chk, $urandom_range(max_gap, 0));
        check("end_flags", {28'd0, busy, cpu_hold, load_done, load_error},
              bad_chk ? 32'b0101 : 32'b0010);
        repeat (3) @(negedge clk);
        check("wr_count", wr_count - wr0, n);
    endtask

    task automatic rand_words(input int n);
        frame_words.delete();
        for (int k = 0; k < n; k++) frame_words.push_back($urandom);
    endtask

    initial begin
        int          wr0;
        logic [7:0]  nb;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        do_reset();

        // Reference frame, good then corrupted checksum.
        frame_words = '{32'h20010001, 32'h20020002};
        run_frame(1'b0, 0);
        run_frame(1'b1, 0);

        // Oversized length: rejected straight after LEN_LO, nothing written.
        wr0 = wr_count;
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        check("oversize_flags", {28'd0, busy, cpu_hold, load_done, load_error}, 32'b0101);
        repeat (3) @(negedge clk);
        check("oversize_wr", wr_count - wr0, 0);

        // Empty frame: checksum is just 00^00.
        frame_words.delete();
        run_frame(1'b0, 1);

        // Reset mid-data: six data bytes in, then the rest must be ignored.
        wr0 = wr_count;
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        foreach (frame_words[i]) ;
        send_byte(8'h20, 0); send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'h20, 0); send_byte(8'h02, 0);
        do_reset();
        send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'h02, 0);
        repeat (3) @(negedge clk);
        check("mid_rst_wr", wr_count - wr0, 1);
        check("mid_rst_flags", {28'd0, busy, cpu_hold, load_done, load_error}, 32'b0100);

        // Leading junk and 3-cycle gaps give the same load.
        send_byte(8'h00, 3);
        send_byte(8'hFF, 3);
        frame_words = '{32'h20010001, 32'h20020002};
        run_frame(1'b0, 3);

        // Exactly full memory.
        rand_words(256);
        run_frame(1'b0, 0);

        // Random frames with junk, gaps and occasional bad checksum.
        for (int f = 0; f < 8; f++) begin
            for (int j = $urandom_range(2, 0); j > 0; j--) begin
                nb = 8'($urandom);
                if (nb == 8'hA5) nb = 8'h5A;
                send_byte(nb, $urandom_range(2, 0));
            end
            rand_words($urandom_range(8, 1));
            run_frame(($urandom_range(3, 0) == 0), 2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
